// File: rtl/bt1_fifo_pkg.sv
// Shared constants for the per-channel slave FIFOs: default geometry and the
// status bit positions the register block uses for the sticky flags.
package bt1_fifo_pkg;

  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 5;
  localparam int STAT_OVF_BIT = 0;
  localparam int STAT_UDF_BIT = 1;

endpackage

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage array: synchronous write, registered synchronous
// read, no reset on either the array or the read register.
module fifo_mem_2p #(
  parameter int DW = 8,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/slave_fifo_param.sv
// Parametrised slave FIFO between a channel source and the bus arbiter, with
// watermark/age-timeout request generation and sticky overflow/underflow.
module slave_fifo_param
  import bt1_fifo_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int REQ_TH = 1,
  parameter int TMO    = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic [DW-1:0] chx_data_i,
  input  logic          chx_valid_i,
  output logic          chx_ready_o,
  input  logic          slvx_en_i,
  input  logic          flush_i,
  input  logic          ovf_clr_i,
  input  logic          a2sx_ack_i,
  output logic          slvx_req_o,
  output logic          slvx_val_o,
  output logic [DW-1:0] slvx_data_o,
  output logic [AW:0]   level_o,
  output logic [AW:0]   margin_o,
  output logic          ovf_o,
  output logic          udf_o
);

  localparam int          DEPTH   = 2**AW;
  localparam int          TW      = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] REQ_LVL = (AW+1)'(REQ_TH);
  localparam logic [TW-1:0] AGE_MAX = TW'(TMO);

  logic [AW:0]   wr_ptr, rd_ptr, level;
  logic [TW-1:0] age_cnt;
  logic          full, empty, wr_en, rd_en, timed_out;
  logic          data_loaded;
  logic [DW-1:0] mem_rdata;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign level_o = level;
  assign margin_o = DEPTH_L - level;

  assign chx_ready_o = slvx_en_i & ~full & ~flush_i;
  assign wr_en       = chx_valid_i & chx_ready_o;
  assign rd_en       = a2sx_ack_i & ~empty & ~flush_i;

  assign timed_out  = (TMO != 0) && (age_cnt == AGE_MAX);
  assign slvx_req_o = ~empty & ((level >= REQ_LVL) | timed_out);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Age counts how long unread data has been waiting; any read restarts it.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      age_cnt <= '0;
    end else if (flush_i || empty || rd_en) begin
      age_cnt <= '0;
    end else if (age_cnt != AGE_MAX) begin
      age_cnt <= age_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      slvx_val_o  <= 1'b0;
      data_loaded <= 1'b0;
    end else begin
      slvx_val_o <= rd_en;
      if (rd_en) data_loaded <= 1'b1;
    end
  end

  // Flush clears the sticky bits outright; otherwise a new event beats a clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else if (flush_i) begin
      ovf_o <= 1'b0;
      udf_o <= 1'b0;
    end else begin
      if (chx_valid_i && slvx_en_i && full) ovf_o <= 1'b1;
      else if (ovf_clr_i)                   ovf_o <= 1'b0;
      if (a2sx_ack_i && empty)              udf_o <= 1'b1;
      else if (ovf_clr_i)                   udf_o <= 1'b0;
    end
  end

  fifo_mem_2p #(.DW(DW), .AW(AW)) u_mem (
    .clk     (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (chx_data_i),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (mem_rdata)
  );

  // The array read register has no reset, so mask it until the first read.
  assign slvx_data_o = data_loaded ? mem_rdata : '0;

endmodule

// File: tb/tb_slave_fifo_param.sv
// Directed bench for slave_fifo_param: a legacy-threshold instance and a
// watermark/timeout instance share the same stimulus.
module tb_slave_fifo_param;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [7:0] chx_data_i;
  logic       chx_valid_i, slvx_en_i, flush_i, ovf_clr_i, a2sx_ack_i;

  logic       ready, req, val, ovf, udf;
  logic [7:0] data;
  logic [5:0] level, margin;
  logic       ready4, req4, val4, ovf4, udf4;
  logic [7:0] data4;
  logic [5:0] level4, margin4;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  slave_fifo_param #(.DW(8), .AW(5), .REQ_TH(1), .TMO(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .chx_data_i(chx_data_i), .chx_valid_i(chx_valid_i),
    .chx_ready_o(ready), .slvx_en_i(slvx_en_i), .flush_i(flush_i), .ovf_clr_i(ovf_clr_i),
    .a2sx_ack_i(a2sx_ack_i), .slvx_req_o(req), .slvx_val_o(val), .slvx_data_o(data),
    .level_o(level), .margin_o(margin), .ovf_o(ovf), .udf_o(udf)
  );

  slave_fifo_param #(.DW(8), .AW(5), .REQ_TH(4), .TMO(16)) dut4 (
    .clk_i(clk_i), .rstn_i(rstn_i), .chx_data_i(chx_data_i), .chx_valid_i(chx_valid_i),
    .chx_ready_o(ready4), .slvx_en_i(slvx_en_i), .flush_i(flush_i), .ovf_clr_i(ovf_clr_i),
    .a2sx_ack_i(a2sx_ack_i), .slvx_req_o(req4), .slvx_val_o(val4), .slvx_data_o(data4),
    .level_o(level4), .margin_o(margin4), .ovf_o(ovf4), .udf_o(udf4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    logic [7:0] wdata;
    logic [7:0] exp_d;
    logic [7:0] q[$];

    rstn_i = 1'b0; chx_data_i = '0; chx_valid_i = 1'b0; slvx_en_i = 1'b1;
    flush_i = 1'b0; ovf_clr_i = 1'b0; a2sx_ack_i = 1'b0;
    #3;
    checkOutput("rst_level", level, 0);
    checkOutput("rst_margin", margin, 32);
    checkOutput("rst_req", req, 0);
    checkOutput("rst_val", val, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_udf", udf, 0);
    checkOutput("rst_ready", ready, 1);
    #10 rstn_i = 1'b1;

    // Fill to full with 0x01..0x20.
    for (int i = 1; i <= 32; i++) begin
      chx_valid_i = 1'b1;
      chx_data_i  = 8'(i);
      #1;
      if (i == 1) checkOutput("fill_ready_first", ready, 1);
      tick();
      if (i == 1) begin
        checkOutput("fill_level1", level, 1);
        checkOutput("fill_req1", req, 1);
        checkOutput("fill_req4_lvl1", req4, 0);
      end
    end
    chx_valid_i = 1'b0;
    #1;
    checkOutput("full_ready", ready, 0);
    checkOutput("full_margin", margin, 0);
    checkOutput("full_level", level, 32);

    chx_valid_i = 1'b1; chx_data_i = 8'hFF;
    tick();
    chx_valid_i = 1'b0;
    checkOutput("ovf_set", ovf, 1);
    checkOutput("ovf_level", level, 32);

    // Full with simultaneous ack and valid: read happens, write is refused.
    chx_valid_i = 1'b1; chx_data_i = 8'hEE; a2sx_ack_i = 1'b1;
    #1;
    checkOutput("fullrw_ready", ready, 0);
    tick();
    chx_valid_i = 1'b0;
    checkOutput("fullrw_level", level, 31);
    checkOutput("fullrw_val", val, 1);
    checkOutput("fullrw_data", data, 8'h01);
    #1;
    checkOutput("fullrw_ready_next", ready, 1);
    for (int i = 2; i <= 32; i++) begin
      tick();
      checkOutput("drain_val", val, 1);
      checkOutput("drain_data", data, 32'(i));
    end
    a2sx_ack_i = 1'b0;
    tick();
    checkOutput("drained_val", val, 0);
    checkOutput("drained_level", level, 0);
    checkOutput("drained_margin", margin, 32);
    checkOutput("drained_req", req, 0);
    checkOutput("drained_hold", data, 8'h20);

    a2sx_ack_i = 1'b1;
    tick();
    a2sx_ack_i = 1'b0;
    checkOutput("udf_set", udf, 1);
    checkOutput("udf_val", val, 0);
    checkOutput("udf_hold", data, 8'h20);
    a2sx_ack_i = 1'b1; ovf_clr_i = 1'b1;
    tick();
    a2sx_ack_i = 1'b0;
    checkOutput("clr_ovf", ovf, 0);
    checkOutput("clr_udf_setwins", udf, 1);
    tick();
    ovf_clr_i = 1'b0;
    checkOutput("clr_udf", udf, 0);

    // Three words below the watermark: request only after the age timeout.
    for (int i = 0; i < 3; i++) begin
      chx_valid_i = 1'b1; chx_data_i = 8'(8'h31 + i);
      tick();
    end
    chx_valid_i = 1'b0;
    checkOutput("tmo_req_early", req4, 0);
    repeat (13) tick();
    checkOutput("tmo_req_15", req4, 0);
    checkOutput("tmo_req_legacy", req, 1);
    tick();
    checkOutput("tmo_req_16", req4, 1);
    checkOutput("tmo_level", level4, 3);
    a2sx_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("tmo_drain_data", data4, 32'(8'h31 + i));
    end
    a2sx_ack_i = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chx_valid_i = 1'b1; chx_data_i = 8'(8'h34 + i);
      tick();
    end
    chx_valid_i = 1'b0;
    repeat (5) tick();
    checkOutput("wm_req_below", req4, 0);
    chx_valid_i = 1'b1; chx_data_i = 8'h37;
    tick();
    chx_valid_i = 1'b0;
    checkOutput("wm_req_at", req4, 1);
    checkOutput("wm_level", level4, 4);
    a2sx_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("wm_drain_data", data, 32'(8'h34 + i));
    end
    a2sx_ack_i = 1'b0;
    tick();

    // Flush with data stored and a read and write both requested.
    a2sx_ack_i = 1'b1;
    tick();
    a2sx_ack_i = 1'b0;
    checkOutput("pre_flush_udf", udf, 1);
    for (int i = 0; i < 10; i++) begin
      chx_valid_i = 1'b1; chx_data_i = 8'(8'h40 + i);
      tick();
    end
    checkOutput("pre_flush_level", level, 10);
    flush_i = 1'b1; a2sx_ack_i = 1'b1; chx_valid_i = 1'b1; chx_data_i = 8'h99;
    #1;
    checkOutput("flush_ready", ready, 0);
    tick();
    flush_i = 1'b0; a2sx_ack_i = 1'b0; chx_valid_i = 1'b0;
    checkOutput("flush_level", level, 0);
    checkOutput("flush_margin", margin, 32);
    checkOutput("flush_val", val, 0);
    checkOutput("flush_req", req, 0);
    checkOutput("flush_udf", udf, 0);
    checkOutput("flush_hold", data, 8'h37);
    chx_valid_i = 1'b1; chx_data_i = 8'h55;
    tick();
    chx_valid_i = 1'b0; a2sx_ack_i = 1'b1;
    tick();
    a2sx_ack_i = 1'b0;
    checkOutput("post_flush_val", val, 1);
    checkOutput("post_flush_data", data, 8'h55);

    // Random interleaved traffic against a queue scoreboard, wrapping pointers.
    wdata = 8'h60;
    for (int c = 0; c < 120; c++) begin
      bit v, a, rd;
      v  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 1) == 1);
      rd = a && (q.size() != 0);
      chx_valid_i = v; chx_data_i = wdata; a2sx_ack_i = a;
      if (rd) exp_d = q.pop_front();
      if (v && (q.size() + (rd ? 1 : 0)) < 32) begin
        q.push_back(wdata);
        wdata = wdata + 8'd1;
      end
      tick();
      checkOutput("wrap_val", val, 32'(rd));
      if (rd) checkOutput("wrap_data", data, exp_d);
      checkOutput("wrap_level", level, 32'(q.size()));
    end
    chx_valid_i = 1'b0; a2sx_ack_i = 1'b0;
    tick();

    #3 rstn_i = 1'b0;
    #1;
    checkOutput("async_rst_level", level, 0);
    checkOutput("async_rst_val", val, 0);
    checkOutput("async_rst_data", data, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
